spi_reg_bank: RTL and testbench
===============================

Name: spi_reg_bank

Overview:
Parametrised SPI register bank between soft_spi_slave and the DSP datapath. It replaces the ad-hoc register handling in the top level. It decodes SPI address/data strobes into:
- control pulses
- per-channel result-shift registers
- a multi-channel FIR coefficient window with handshaked readback and timeout
- a sticky status register
- a read-only device ID

Parameters:
DATA_W, 24, SPI data word width
ADDR_W, 7, SPI address width (fixed map below requires 7)
CH_COUNT, 2, number of filter channels, 1..3
COEF_IDX_W, 4, coefficient index width (16 per channel)
SHIFT_W, 5, result-shift field width
RD_TIMEOUT, 15, max cycles to wait for coef_rd_valid, 1..255
DEVICE_ID, 24'hF0CCAB, value returned at 0x7F

Ports:
clk  in  1  system clock (hs_clk domain)
rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_W  SPI address, stable while addr_ready high
addr_ready  in  1  level; rising edge = new transaction
rw  in  1  1 = read, 0 = write
data_wr  in  DATA_W  SPI received word, stable while data_ready high
data_ready  in  1  level; rising edge = word received
data_rd  out  DATA_W  word presented to SPI shift-out
soft_rst_o  out  1  soft reset request
flush_o  out  CH_COUNT  per-channel FIR flush pulse
shift_o  out  CH_COUNT*SHIFT_W  per-channel result shift, flat, ch0 in LSBs
shift_upd_o  out  CH_COUNT  1-cycle update strobe per channel
coef_ch  out  2  target channel
coef_idx  out  COEF_IDX_W  target coefficient index
coef_data  out  DATA_W  coefficient write data
coef_wr  out  1  1-cycle write strobe
coef_rd_req  out  1  1-cycle read request
coef_rd_valid  in  1  readback valid
coef_rd_data  in  DATA_W  readback data

Behaviour:
- Reset: all outputs 0, shift registers 0, status 0, FSM IDLE, edge-detect history 0.
- Edge detection: addr_ready and data_ready are registered once. The rise of either is acted on in the cycle it is detected. A level held high never retriggers.
- Address map:
  - 0x00 CTRL: write-only; reads return 0.
  - 0x01 STATUS: bit0 rd_timeout, bit1 bad_addr_write; read returns and clears.
  - 0x08+c SHIFT_c: R/W for c < CH_COUNT.
  - 0x40+16c+i COEF: R/W for c < CH_COUNT.
  - 0x7F ID: read-only.
  - Anything else reads 0.
- Read, on addr_ready rise:
  - Non-COEF address: data_rd updates exactly 1 cycle later.
  - COEF address: latch coef_ch/coef_idx, pulse coef_rd_req for 1 cycle, drive data_rd=0, enter RD_WAIT.
- RD_WAIT:
  - coef_rd_valid high: data_rd <= coef_rd_data; go to IDLE.
  - RD_TIMEOUT cycles elapse without valid: data_rd=0, set status bit0, go to IDLE.
  - coef_rd_valid arriving while IDLE is ignored.
- Write, on data_ready rise with rw=0, using the latched address:
  - CTRL bit0: assert soft_rst_o; hold it until data_ready falls (minimum 1 cycle).
  - CTRL bit(1+c): 1-cycle flush_o[c] pulse.
  - SHIFT_c: load data_wr[SHIFT_W-1:0]; 1-cycle shift_upd_o[c].
  - COEF: coef_data <= data_wr; 1-cycle coef_wr pulse.
  - ID, STATUS, or unmapped address: no effect except setting status bit1.
  - Writes with rw=1 are ignored.
- After a SHIFT or COEF write, data_rd reflects the new value from the next cycle.
- Simultaneous events:
  - New addr_ready rise during RD_WAIT aborts the pending read and no-timeout is flagged; the new transaction proceeds.
  - data_ready rise during RD_WAIT performs the write and keeps waiting.
  - Status read in the same cycle as a new flag: the flag survives (set wins over clear).
- rst_n low mid-operation: immediate return to reset values; any pending read is dropped without a strobe.
- Timeout counter: 8 bits, saturating, cleared on entry to RD_WAIT.

Test Plan:
- Reset, then read 0x7F -> data_rd = 0xF0CCAB one cycle after addr_ready rise. Then read 0x05 -> data_rd = 0.
- Write 0x09 with 0x00001B -> shift_o[9:5] = 5'd27, shift_upd_o = 2'b10 for exactly 1 cycle. Read 0x09 -> 0x00001B.
- Write 0x55 with 0x123456 -> coef_ch = 1, coef_idx = 5, coef_data = 0x123456, coef_wr high 1 cycle.
- Read 0x43, responder answers after 3 cycles with 0xABCDEF -> single coef_rd_req, data_rd = 0 until valid, then 0xABCDEF.
- Read 0x43 with no responder -> data_rd = 0 after RD_TIMEOUT = 15 cycles. Next STATUS read returns 0x1; following STATUS read returns 0x0.
- Write CTRL with 0x5 (CH_COUNT = 2) -> soft_rst_o high until data_ready falls, flush_o = 2'b10 for 1 cycle. Drop rst_n mid-RD_WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/spi_reg_bank_if.sv
// SPI-side register access bus: address/data strobes from soft_spi_slave and the
// readback word shifted out to the SPI master.
interface spi_reg_bank_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 24
);
    logic [ADDR_W-1:0] addr;
    logic              addr_ready;
    logic              rw;
    logic [DATA_W-1:0] data_wr;
    logic              data_ready;
    logic [DATA_W-1:0] data_rd;

    modport master (output addr, addr_ready, rw, data_wr, data_ready, input data_rd);
    modport slave  (input addr, addr_ready, rw, data_wr, data_ready, output data_rd);
endinterface

// File: rtl/spi_reg_bank.sv
// Register bank between the SPI slave and the DSP datapath: control pulses,
// per-channel result shifts, FIR coefficient window with timed readback, status, ID.
module spi_reg_bank #(
    parameter int              DATA_W     = 24,
    parameter int              ADDR_W     = 7,
    parameter int              CH_COUNT   = 2,
    parameter int              COEF_IDX_W = 4,
    parameter int              SHIFT_W    = 5,
    parameter int              RD_TIMEOUT = 15,
    parameter logic [DATA_W-1:0] DEVICE_ID = 24'hF0CCAB
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_reg_bank_if.slave                spi,
    output logic                         soft_rst_o,
    output logic [CH_COUNT-1:0]          flush_o,
    output logic [CH_COUNT*SHIFT_W-1:0]  shift_o,
    output logic [CH_COUNT-1:0]          shift_upd_o,
    output logic [1:0]                   coef_ch,
    output logic [COEF_IDX_W-1:0]        coef_idx,
    output logic [DATA_W-1:0]            coef_data,
    output logic                         coef_wr,
    output logic                         coef_rd_req,
    input  logic                         coef_rd_valid,
    input  logic [DATA_W-1:0]            coef_rd_data
);
    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

    function automatic logic is_coef(input logic [ADDR_W-1:0] a);
        return a[6] && (32'(a[5:4]) < CH_COUNT);
    endfunction

    state_t                           state_q, state_d;
    logic                             addr_q, data_q, addr_rise, data_rise;
    logic [ADDR_W-1:0]                addr_lat;
    logic                             rw_lat;
    logic [CH_COUNT-1:0][SHIFT_W-1:0] shift_q;
    logic [1:0]                       status_q;
    logic [7:0]                       to_cnt;
    logic [DATA_W-1:0]                data_rd_q, rd_mux;
    logic                             rd_req, rd_done, rd_to;
    logic                             wr_ev, wr_ctrl, wr_coef, wr_bad, status_clr;
    logic [CH_COUNT-1:0]              wr_shift;

    assign addr_rise   = spi.addr_ready && !addr_q;
    assign data_rise   = spi.data_ready && !data_q;
    assign spi.data_rd = data_rd_q;
    assign shift_o     = shift_q;

    assign wr_ev      = data_rise && !rw_lat;
    assign wr_ctrl    = wr_ev && (addr_lat == '0);
    assign wr_coef    = wr_ev && is_coef(addr_lat);
    assign wr_bad     = wr_ev && !((addr_lat == '0) || (|wr_shift) || is_coef(addr_lat));
    assign status_clr = addr_rise && spi.rw && (spi.addr == ADDR_W'(1));

    always_comb begin
        wr_shift = '0;
        rd_mux   = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            wr_shift[c] = wr_ev && (addr_lat == ADDR_W'(8 + c));
            if (spi.addr == ADDR_W'(8 + c))
                rd_mux = DATA_W'(shift_q[c]);
        end
        if (spi.addr == ADDR_W'(1))
            rd_mux = DATA_W'(status_q);
        else if (spi.addr == ADDR_W'('h7F))
            rd_mux = DEVICE_ID;
    end

    // A new address strobe always wins: it aborts any pending coefficient read.
    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        rd_done = 1'b0;
        rd_to   = 1'b0;
        if (addr_rise) begin
            if (spi.rw && is_coef(spi.addr)) begin
                rd_req  = 1'b1;
                state_d = RD_WAIT;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == RD_WAIT) begin
            if (coef_rd_valid) begin
                rd_done = 1'b1;
                state_d = IDLE;
            end else if (to_cnt >= TO_LAST) begin
                rd_to   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= 1'b0;
            data_q      <= 1'b0;
            addr_lat    <= '0;
            rw_lat      <= 1'b0;
            to_cnt      <= '0;
            status_q    <= '0;
            shift_q     <= '0;
            data_rd_q   <= '0;
            soft_rst_o  <= 1'b0;
            flush_o     <= '0;
            shift_upd_o <= '0;
            coef_ch     <= '0;
            coef_idx    <= '0;
            coef_data   <= '0;
            coef_wr     <= 1'b0;
            coef_rd_req <= 1'b0;
        end else begin
            addr_q <= spi.addr_ready;
            data_q <= spi.data_ready;
            if (addr_rise) begin
                addr_lat <= spi.addr;
                rw_lat   <= spi.rw;
            end

            if (rd_req)
                to_cnt <= '0;
            else if (state_q == RD_WAIT && to_cnt != 8'hFF)
                to_cnt <= to_cnt + 8'd1;

            // Set terms are OR-ed after the clear so a same-cycle flag survives.
            status_q <= (status_q & ~{2{status_clr}}) | {wr_bad, rd_to};

            soft_rst_o  <= (wr_ctrl && spi.data_wr[0]) || (soft_rst_o && spi.data_ready);
            coef_rd_req <= rd_req;
            coef_wr     <= wr_coef;
            if (rd_req) begin
                coef_ch  <= spi.addr[5:4];
                coef_idx <= spi.addr[COEF_IDX_W-1:0];
            end else if (wr_coef) begin
                coef_ch   <= addr_lat[5:4];
                coef_idx  <= addr_lat[COEF_IDX_W-1:0];
                coef_data <= spi.data_wr;
            end

            for (int c = 0; c < CH_COUNT; c++) begin
                flush_o[c]     <= wr_ctrl && spi.data_wr[1 + c];
                shift_upd_o[c] <= wr_shift[c];
                if (wr_shift[c])
                    shift_q[c] <= spi.data_wr[SHIFT_W-1:0];
            end

            if (addr_rise && spi.rw)
                data_rd_q <= rd_req ? '0 : rd_mux;
            else if (rd_done)
                data_rd_q <= coef_rd_data;
            else if (rd_to)
                data_rd_q <= '0;
            else if (wr_coef)
                data_rd_q <= spi.data_wr;
            else if (|wr_shift)
                data_rd_q <= DATA_W'(spi.data_wr[SHIFT_W-1:0]);
        end
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: vector table of SPI reads/writes plus
// hand sequences for coefficient readback, timeout, abort, CTRL and reset.
module tb_spi_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        soft_rst_o;
    logic [1:0]  flush_o;
    logic [9:0]  shift_o;
    logic [1:0]  shift_upd_o;
    logic [1:0]  coef_ch;
    logic [3:0]  coef_idx;
    logic [23:0] coef_data;
    logic        coef_wr;
    logic        coef_rd_req;
    logic        coef_rd_valid;
    logic [23:0] coef_rd_data;

    spi_reg_bank_if #(.ADDR_W(7), .DATA_W(24)) bus();

    spi_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .spi(bus),
        .soft_rst_o(soft_rst_o), .flush_o(flush_o), .shift_o(shift_o),
        .shift_upd_o(shift_upd_o), .coef_ch(coef_ch), .coef_idx(coef_idx),
        .coef_data(coef_data), .coef_wr(coef_wr), .coef_rd_req(coef_rd_req),
        .coef_rd_valid(coef_rd_valid), .coef_rd_data(coef_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [6:0]  a;
        logic [23:0] d;
        logic [23:0] exp_rd;
        logic [1:0]  exp_upd;
        logic        exp_cwr;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    logic [1:0] snap_upd, snap2_upd;
    logic       snap_cwr, snap2_cwr;

    always @(negedge clk) if (coef_rd_req) req_cnt++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] outs_all();
        return 128'({bus.data_rd, soft_rst_o, flush_o, shift_o, shift_upd_o,
                     coef_ch, coef_idx, coef_data, coef_wr, coef_rd_req});
    endfunction

    task automatic spi_read(input logic [6:0] a);
        @(negedge clk);
        bus.addr = a; bus.rw = 1'b1; bus.addr_ready = 1'b1;
        @(negedge clk);
        bus.addr_ready = 1'b0;
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [23:0] d);
        @(negedge clk);
        bus.addr = a; bus.rw = 1'b0; bus.addr_ready = 1'b1;
        @(negedge clk);
        bus.addr_ready = 1'b0; bus.data_wr = d; bus.data_ready = 1'b1;
        @(negedge clk);
        snap_upd = shift_upd_o; snap_cwr = coef_wr;
        bus.data_ready = 1'b0;
        @(negedge clk);
        snap2_upd = shift_upd_o; snap2_cwr = coef_wr;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.addr = '0; bus.addr_ready = 1'b0; bus.rw = 1'b0;
        bus.data_wr = '0; bus.data_ready = 1'b0;
        coef_rd_valid = 1'b0; coef_rd_data = '0; rst_n = 1'b0;

        vecs[0]  = '{0, 7'h7F, 24'h0,      24'hF0CCAB, 2'b00, 1'b0};
        vecs[1]  = '{0, 7'h05, 24'h0,      24'h000000, 2'b00, 1'b0};
        vecs[2]  = '{0, 7'h7F, 24'h0,      24'hF0CCAB, 2'b00, 1'b0};
        vecs[3]  = '{0, 7'h00, 24'h0,      24'h000000, 2'b00, 1'b0};
        vecs[4]  = '{1, 7'h09, 24'h00001B, 24'h00001B, 2'b10, 1'b0};
        vecs[5]  = '{0, 7'h7F, 24'h0,      24'hF0CCAB, 2'b00, 1'b0};
        vecs[6]  = '{0, 7'h09, 24'h0,      24'h00001B, 2'b00, 1'b0};
        vecs[7]  = '{0, 7'h08, 24'h0,      24'h000000, 2'b00, 1'b0};
        vecs[8]  = '{1, 7'h08, 24'hFFFFF3, 24'h000013, 2'b01, 1'b0};
        vecs[9]  = '{0, 7'h08, 24'h0,      24'h000013, 2'b00, 1'b0};
        vecs[10] = '{0, 7'h0A, 24'h0,      24'h000000, 2'b00, 1'b0};
        vecs[11] = '{1, 7'h7F, 24'h0,      24'h000000, 2'b00, 1'b0};
        vecs[12] = '{0, 7'h01, 24'h0,      24'h000002, 2'b00, 1'b0};
        vecs[13] = '{0, 7'h01, 24'h0,      24'h000000, 2'b00, 1'b0};
        vecs[14] = '{1, 7'h55, 24'h123456, 24'h123456, 2'b00, 1'b1};
        vecs[15] = '{0, 7'h09, 24'h0,      24'h00001B, 2'b00, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outs", outs_all(), 128'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                spi_write(vecs[i].a, vecs[i].d);
                chk($sformatf("v%0d_upd", i), 128'(snap_upd), 128'(vecs[i].exp_upd));
                chk($sformatf("v%0d_cwr", i), 128'(snap_cwr), 128'(vecs[i].exp_cwr));
                chk($sformatf("v%0d_pulse_end", i), 128'({snap2_upd, snap2_cwr}), 128'h0);
            end else begin
                spi_read(vecs[i].a);
            end
            chk($sformatf("v%0d_rd", i), 128'(bus.data_rd), 128'(vecs[i].exp_rd));
        end
        chk("shift_o", 128'(shift_o), 128'h373);
        chk("coef_wr_target", 128'({coef_ch, coef_idx, coef_data}), 128'({2'd1, 4'd5, 24'h123456}));

        // write strobe while the latched transaction is a read: ignored
        spi_read(7'h09);
        @(negedge clk);
        bus.data_wr = 24'h00001F; bus.data_ready = 1'b1;
        @(negedge clk);
        chk("rw1_write_upd", 128'(shift_upd_o), 128'h0);
        bus.data_ready = 1'b0;
        @(negedge clk);
        chk("rw1_write_shift", 128'(shift_o), 128'h373);

        // coefficient readback answered after 3 cycles
        req_cnt = 0;
        spi_read(7'h43);
        chk("crd_req", 128'(coef_rd_req), 128'h1);
        chk("crd_target", 128'({coef_ch, coef_idx}), 128'h03);
        chk("crd_rd_zero", 128'(bus.data_rd), 128'h0);
        repeat (2) begin
            @(negedge clk);
            chk("crd_wait_zero", 128'(bus.data_rd), 128'h0);
        end
        coef_rd_valid = 1'b1; coef_rd_data = 24'hABCDEF;
        @(negedge clk);
        coef_rd_valid = 1'b0;
        chk("crd_data", 128'(bus.data_rd), 128'hABCDEF);
        chk("crd_req_count", 128'(req_cnt), 128'h1);

        // valid on the last allowed wait cycle is still accepted
        spi_read(7'h43);
        repeat (14) @(negedge clk);
        coef_rd_valid = 1'b1; coef_rd_data = 24'h5A5A5A;
        @(negedge clk);
        coef_rd_valid = 1'b0;
        chk("crd_last_cycle", 128'(bus.data_rd), 128'h5A5A5A);

        // one cycle later is a timeout; the late valid is ignored
        spi_read(7'h43);
        repeat (15) @(negedge clk);
        coef_rd_valid = 1'b1; coef_rd_data = 24'h777777;
        @(negedge clk);
        coef_rd_valid = 1'b0;
        chk("timeout_late_valid", 128'(bus.data_rd), 128'h0);
        spi_read(7'h01);
        chk("status_timeout", 128'(bus.data_rd), 128'h1);
        spi_read(7'h01);
        chk("status_cleared", 128'(bus.data_rd), 128'h0);

        // CTRL: soft reset held with data_ready, flush ch1
        @(negedge clk);
        bus.addr = 7'h00; bus.rw = 1'b0; bus.addr_ready = 1'b1;
        @(negedge clk);
        bus.addr_ready = 1'b0; bus.data_wr = 24'h000005; bus.data_ready = 1'b1;
        @(negedge clk);
        chk("ctrl_pulse", 128'({soft_rst_o, flush_o}), 128'({1'b1, 2'b10}));
        @(negedge clk);
        chk("ctrl_hold", 128'({soft_rst_o, flush_o}), 128'({1'b1, 2'b00}));
        bus.data_ready = 1'b0;
        @(negedge clk);
        chk("ctrl_release", 128'(soft_rst_o), 128'h0);

        // new address during RD_WAIT aborts without timeout
        spi_read(7'h43);
        @(negedge clk);
        spi_read(7'h7F);
        chk("abort_new_read", 128'(bus.data_rd), 128'hF0CCAB);
        coef_rd_valid = 1'b1; coef_rd_data = 24'h999999;
        @(negedge clk);
        coef_rd_valid = 1'b0;
        chk("abort_valid_ignored", 128'(bus.data_rd), 128'hF0CCAB);
        repeat (20) @(negedge clk);
        spi_read(7'h01);
        chk("abort_no_timeout", 128'(bus.data_rd), 128'h0);

        // async reset mid RD_WAIT
        spi_read(7'h43);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", outs_all(), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset", outs_all(), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
